// File: rtl/dest_scoreboard.sv
// In-order destination-register scoreboard: FIFO of {we, rd} per in-flight
// instruction plus per-register pending-write counters for RAW stalls.
module dest_scoreboard #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [2:0]       issue_rd,
  output logic             issue_ready,
  input  logic [2:0]       rs,
  input  logic             rs_used,
  input  logic [2:0]       rt,
  input  logic             rt_used,
  output logic             hazard,
  input  logic             wb_valid,
  output logic             wb_we,
  output logic [2:0]       wb_rd,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             we_q [DEPTH];
  logic [2:0]       rd_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q [8];
  logic [CNT_W-1:0] pend_d [8];
  logic [7:0]       inc, dec;
  logic             push, pop;
  logic             head_we;
  logic [2:0]       head_rd;

  assign empty       = (cnt_q == '0);
  assign issue_ready = (cnt_q != FULL);
  assign count       = cnt_q;
  assign push        = issue_valid && issue_ready;
  assign pop         = wb_valid && !empty;
  assign head_we     = we_q[rd_ptr_q];
  assign head_rd     = rd_q[rd_ptr_q];
  assign wb_we       = head_we && !empty;
  assign wb_rd       = empty ? 3'd0 : head_rd;

  // Only registered counters feed hazard, so a same-cycle issue never
  // stalls the instruction that is issuing it.
  assign hazard = (rs_used && (pend_q[rs] != '0))
               || (rt_used && (pend_q[rt] != '0));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q;
    inc      = '0;
    dec      = '0;
    if (push && !pop) cnt_d = cnt_q + ONE;
    if (pop && !push) cnt_d = cnt_q - ONE;
    for (int i = 0; i < 8; i++) begin
      inc[i]    = push && issue_we && (issue_rd == 3'(i));
      dec[i]    = pop && head_we && (head_rd == 3'(i));
      pend_d[i] = pend_q[i];
      if (inc[i] && !dec[i]) pend_d[i] = pend_q[i] + ONE;
      if (dec[i] && !inc[i]) pend_d[i] = pend_q[i] - ONE;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      for (int i = 0; i < 8; i++) pend_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 8; i++) pend_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        we_q[i] <= 1'b0;
        rd_q[i] <= 3'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < 8; i++) pend_q[i] <= pend_d[i];
      if (push && !flush) begin
        we_q[wr_ptr_q] <= issue_we;
        rd_q[wr_ptr_q] <= issue_rd;
      end
    end
  end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Bench for dest_scoreboard: directed scenarios plus random traffic
// against a queue-based model of in-flight {we, rd} entries.
module tb_dest_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_we = 1'b0;
  logic [2:0] issue_rd = 3'd0;
  logic       issue_ready;
  logic [2:0] rs = 3'd0;
  logic       rs_used = 1'b0;
  logic [2:0] rt = 3'd0;
  logic       rt_used = 1'b0;
  logic       hazard;
  logic       wb_valid = 1'b0;
  logic       wb_we;
  logic [2:0] wb_rd;
  logic       empty;
  logic [2:0] count;

  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] mq[$];

  dest_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs(rs), .rs_used(rs_used), .rt(rt), .rt_used(rt_used),
    .hazard(hazard), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic m_pending(input logic [2:0] r);
    foreach (mq[k]) if (mq[k][3] && mq[k][2:0] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge,
  // return at the following negedge with control inputs idle.
  task automatic step(input logic iv, input logic iwe,
                      input logic [2:0] ird, input logic wbv,
                      input logic fl);
    logic acc, ret;
    issue_valid = iv; issue_we = iwe; issue_rd = ird;
    wb_valid = wbv; flush = fl;
    @(posedge clk);
    acc = iv && (mq.size() < 4);
    ret = wbv && (mq.size() > 0);
    if (fl) mq.delete();
    else begin
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back({iwe, ird});
    end
    @(negedge clk);
    issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rs = 3'd0; rs_used = 1'b1;
    #2;
    n_chk++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", issue_ready); else n_pass++;
    n_chk++; if ({wb_we, wb_rd} !== 4'd0) $display("FAIL reset_wb got %b want 0000", {wb_we, wb_rd}); else n_pass++;
    n_chk++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", hazard); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    rs_used = 1'b0;
  endtask

  task automatic test_basic;
    step(1, 1, 3'd3, 0, 0);
    n_chk++; if (count !== 3'd1) $display("FAIL basic_count got %0d want 1", count); else n_pass++;
    n_chk++; if ({wb_we, wb_rd} !== 4'b1011) $display("FAIL basic_wb got %b want 1011", {wb_we, wb_rd}); else n_pass++;
    rs = 3'd3; rs_used = 1'b1; #1;
    n_chk++; if (hazard !== 1'b1) $display("FAIL basic_haz_r3 got %b want 1", hazard); else n_pass++;
    rs = 3'd4; #1;
    n_chk++; if (hazard !== 1'b0) $display("FAIL basic_haz_r4 got %b want 0", hazard); else n_pass++;
    rs_used = 1'b0;
    step(0, 0, 3'd0, 1, 0);
    n_chk++; if (empty !== 1'b1) $display("FAIL basic_drain got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_multi;
    step(1, 1, 3'd5, 0, 0);
    step(1, 1, 3'd5, 0, 0);
    step(1, 0, 3'd1, 0, 0);
    step(0, 0, 3'd0, 1, 0);
    rs = 3'd5; rs_used = 1'b1; #1;
    n_chk++; if (hazard !== 1'b1) $display("FAIL multi_haz_one_left got %b want 1", hazard); else n_pass++;
    step(0, 0, 3'd0, 1, 0);
    #1;
    n_chk++; if (hazard !== 1'b0) $display("FAIL multi_haz_clear got %b want 0", hazard); else n_pass++;
    n_chk++; if (wb_we !== 1'b0) $display("FAIL multi_wb_we got %b want 0", wb_we); else n_pass++;
    n_chk++; if (count !== 3'd1) $display("FAIL multi_count got %0d want 1", count); else n_pass++;
    rs_used = 1'b0;
    step(0, 0, 3'd0, 1, 0);
  endtask

  task automatic test_full;
    logic [2:0] order [4];
    order[0] = 3'd1; order[1] = 3'd2; order[2] = 3'd3; order[3] = 3'd7;
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 3'(i), 0, 0);
    n_chk++; if (issue_ready !== 1'b0) $display("FAIL full_ready got %b want 0", issue_ready); else n_pass++;
    n_chk++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else n_pass++;
    step(1, 1, 3'd6, 1, 0);
    n_chk++; if (count !== 3'd3) $display("FAIL full_refuse_count got %0d want 3", count); else n_pass++;
    rs = 3'd6; rs_used = 1'b1; #1;
    n_chk++; if (hazard !== 1'b0) $display("FAIL full_refused_r6 got %b want 0", hazard); else n_pass++;
    step(1, 1, 3'd7, 0, 0);
    rs = 3'd7; #1;
    n_chk++; if (hazard !== 1'b1) $display("FAIL full_wrap_r7 got %b want 1", hazard); else n_pass++;
    rs = 3'd0; #1;
    n_chk++; if (hazard !== 1'b0) $display("FAIL full_retired_r0 got %b want 0", hazard); else n_pass++;
    rs_used = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (wb_rd !== order[i]) $display("FAIL full_order%0d got %0d want %0d", i, wb_rd, order[i]); else n_pass++;
      step(0, 0, 3'd0, 1, 0);
    end
  endtask

  task automatic test_same_reg;
    step(1, 1, 3'd2, 0, 0);
    step(1, 1, 3'd2, 1, 0);
    rs = 3'd2; rs_used = 1'b1; #1;
    n_chk++; if (count !== 3'd1) $display("FAIL same_count got %0d want 1", count); else n_pass++;
    n_chk++; if (hazard !== 1'b1) $display("FAIL same_haz got %b want 1", hazard); else n_pass++;
    step(0, 0, 3'd0, 1, 0);
    #1;
    n_chk++; if (hazard !== 1'b0) $display("FAIL same_haz_after got %b want 0", hazard); else n_pass++;
    rs_used = 1'b0;
  endtask

  task automatic test_empty_flush;
    step(0, 0, 3'd0, 1, 0);
    n_chk++; if ({empty, count, wb_we, wb_rd} !== 8'b1000_0000) $display("FAIL empty_pop got %b want 10000000", {empty, count, wb_we, wb_rd}); else n_pass++;
    step(1, 1, 3'd1, 0, 0);
    step(1, 1, 3'd2, 0, 0);
    step(1, 1, 3'd3, 0, 0);
    step(1, 1, 3'd4, 0, 1);
    n_chk++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      rs = 3'(r); rt = 3'(7 - r); rs_used = 1'b1; rt_used = 1'b1; #1;
      n_chk++; if (hazard !== 1'b0) $display("FAIL flush_haz_r%0d got %b want 0", r, hazard); else n_pass++;
    end
    rs_used = 1'b0; rt_used = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0] hd;
    logic want;
    step(0, 0, 3'd0, 0, 1);
    for (int c = 0; c < 300; c++) begin
      hd = (mq.size() > 0) ? mq[0] : 4'd0;
      n_chk++; if (count !== 3'(mq.size())) $display("FAIL rand_count c%0d got %0d want %0d", c, count, mq.size()); else n_pass++;
      n_chk++; if ({wb_we, wb_rd} !== hd) $display("FAIL rand_head c%0d got %b want %b", c, {wb_we, wb_rd}, hd); else n_pass++;
      n_chk++; if (issue_ready !== (mq.size() < 4)) $display("FAIL rand_ready c%0d got %b", c, issue_ready); else n_pass++;
      for (int r = 0; r < 8; r++) begin
        rs = 3'(r); rs_used = 1'b1;
        rt = 3'($urandom_range(0, 7)); rt_used = 1'($urandom_range(0, 1));
        want = m_pending(rs) || (rt_used && m_pending(rt));
        #1;
        n_chk++; if (hazard !== want) $display("FAIL rand_haz c%0d r%0d got %b want %b", c, r, hazard, want); else n_pass++;
      end
      rs_used = 1'b0; rt_used = 1'b0;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end
  endtask

  task automatic test_async_reset;
    step(0, 0, 3'd0, 0, 1);
    step(1, 1, 3'd6, 0, 0);
    step(1, 1, 3'd1, 0, 0);
    rs = 3'd6; rs_used = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0) $display("FAIL arst_count got %0d want 0", count); else n_pass++;
    n_chk++; if (empty !== 1'b1 || issue_ready !== 1'b1) $display("FAIL arst_flags got %b%b want 11", empty, issue_ready); else n_pass++;
    n_chk++; if ({wb_we, wb_rd} !== 4'd0) $display("FAIL arst_wb got %b want 0000", {wb_we, wb_rd}); else n_pass++;
    n_chk++; if (hazard !== 1'b0) $display("FAIL arst_haz got %b want 0", hazard); else n_pass++;
    mq.delete();
    @(negedge clk); rst_n = 1'b1;
    rs_used = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_full();
    test_same_reg();
    test_empty_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
